// File: rtl/ring_sequence_monitor.sv
// Health monitor for a one-hot rotating ring counter: one-hot check, rotation check, lock FSM and revolution count.
// Latency 1 cycle, all outputs registered; no backpressure (en=0 holds state). Optional error counter: RING_SEQ_MON_ERRCNT_EN.
module ring_sequence_monitor #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned REV_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] phase,
    output logic                     locked,
    output logic                     err_onehot,
    output logic                     err_seq,
    output logic                     err_sticky,
    output logic                     rev_tick,
    output logic [REV_W-1:0]         rev_count,
    output logic [7:0]               err_count
);
    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic [IW-1:0]    phase_nxt, idx;
    logic [GW-1:0]    good_cnt, good_nxt;
    logic             eo_nxt, es_nxt, tick_nxt, is_onehot, is_valid;
    logic [REV_W-1:0] rev_nxt;
    logic             sticky_nxt;

    always_comb begin
        is_onehot = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
        is_valid  = (ring_in == {prev[WIDTH-2:0], prev[WIDTH-1]});
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) idx = IW'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        phase_nxt = phase;
        good_nxt  = good_cnt;
        eo_nxt    = 1'b0;
        es_nxt    = 1'b0;
        tick_nxt  = 1'b0;
        if (en) begin
            if (state == SEARCH) begin
                if (is_onehot) begin
                    prev_nxt  = ring_in;
                    phase_nxt = idx;
                    good_nxt  = '0;
                    state_nxt = ACQUIRE;
                end else begin
                    eo_nxt = 1'b1;
                end
            end else if (!is_onehot) begin
                // Keep the last good reference so phase stays meaningful while searching.
                eo_nxt    = 1'b1;
                state_nxt = SEARCH;
                good_nxt  = '0;
            end else if (!is_valid) begin
                es_nxt    = 1'b1;
                prev_nxt  = ring_in;
                phase_nxt = idx;
                good_nxt  = '0;
                state_nxt = ACQUIRE;
            end else begin
                prev_nxt  = ring_in;
                phase_nxt = idx;
                if (state == LOCKED) begin
                    tick_nxt = (idx == '0);
                end else begin
                    good_nxt = good_cnt + GW'(1);
                    if (good_cnt + GW'(1) == GW'(LOCK_COUNT)) state_nxt = LOCKED;
                end
            end
        end
    end

    // clr takes effect first so same-cycle events still register.
    always_comb begin
        rev_nxt    = (clr ? '0 : rev_count) + REV_W'(tick_nxt);
        sticky_nxt = (clr ? 1'b0 : err_sticky) | eo_nxt | es_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            prev       <= '0;
            phase      <= '0;
            good_cnt   <= '0;
            err_onehot <= 1'b0;
            err_seq    <= 1'b0;
            rev_tick   <= 1'b0;
            rev_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            phase      <= phase_nxt;
            good_cnt   <= good_nxt;
            err_onehot <= eo_nxt;
            err_seq    <= es_nxt;
            rev_tick   <= tick_nxt;
            rev_count  <= rev_nxt;
            err_sticky <= sticky_nxt;
        end
    end

    assign locked = (state == LOCKED);

`ifdef RING_SEQ_MON_ERRCNT_EN
    logic [7:0] ec_base;

    always_comb begin
        ec_base = clr ? 8'd0 : err_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if ((eo_nxt || es_nxt) && ec_base != 8'hFF) begin
            err_count <= ec_base + 8'd1;
        end else begin
            err_count <= ec_base;
        end
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Randomised and directed bench for ring_sequence_monitor against an index-level behavioural model.
module tb_ring_sequence_monitor;
    localparam int W    = 4;
    localparam int LOCK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  ring_in = 4'b0000;
    logic        clr = 1'b0;
    logic [1:0]  phase;
    logic        locked, err_onehot, err_seq, err_sticky, rev_tick;
    logic [15:0] rev_count;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0=search 1=acquire 2=locked, indices as plain integers.
    int m_mode, m_prev, m_phase, m_good, m_rev, m_ec;
    bit m_eo, m_es, m_st, m_rt;

    ring_sequence_monitor #(.WIDTH(W), .LOCK_COUNT(LOCK), .REV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ring_in(ring_in), .clr(clr),
        .phase(phase), .locked(locked), .err_onehot(err_onehot), .err_seq(err_seq),
        .err_sticky(err_sticky), .rev_tick(rev_tick), .rev_count(rev_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] dut_vec();
        return {phase, locked, err_onehot, err_seq, err_sticky, rev_tick, rev_count, err_count};
    endfunction

    function automatic logic [30:0] mdl_vec();
        return {m_phase[1:0], m_mode == 2, m_eo, m_es, m_st, m_rt, m_rev[15:0], m_ec[7:0]};
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_prev = 0; m_phase = 0; m_good = 0; m_rev = 0; m_ec = 0;
        m_eo = 0; m_es = 0; m_st = 0; m_rt = 0;
    endfunction

    function automatic void model_step(input bit e, input logic [3:0] r, input bit c);
        int idx;
        m_eo = 0; m_es = 0; m_rt = 0;
        if (c) begin m_rev = 0; m_st = 0; m_ec = 0; end
        if (!e) return;
        idx = 0;
        for (int i = 0; i < W; i++) if (r[i]) idx = i;
        if ($countones(r) != 1) begin
            m_eo = 1;
            if (m_mode != 0) begin m_mode = 0; m_good = 0; end
        end else if (m_mode == 0) begin
            m_prev = idx; m_phase = idx; m_good = 0; m_mode = 1;
        end else if (idx != (m_prev + 1) % W) begin
            m_es = 1; m_prev = idx; m_phase = idx; m_good = 0; m_mode = 1;
        end else begin
            m_prev = idx; m_phase = idx;
            if (m_mode == 2) m_rt = (idx == 0);
            else begin
                m_good++;
                if (m_good == LOCK) m_mode = 2;
            end
        end
        if (m_rt) m_rev = (m_rev + 1) % 65536;
        if (m_eo || m_es) begin
            m_st = 1;
`ifdef RING_SEQ_MON_ERRCNT_EN
            if (m_ec < 255) m_ec++;
`endif
        end
    endfunction

    task automatic step(input bit e, input logic [3:0] r, input bit c);
        en = e; ring_in = r; clr = c;
        @(posedge clk); #1;
        model_step(e, r, c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== 31'h0) $display("FAIL reset_vec got=%h exp=0", dut_vec()); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lock_sequence();
        for (int s = 1; s <= 13; s++) begin
            step(1, 4'b0001 << ((s - 1) % 4), 0);
            n_checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL lock_seq s=%0d got=%h exp=%h", s, dut_vec(), mdl_vec()); else n_pass++;
            n_checks++;
            if (locked !== (s >= 5)) $display("FAIL lock_rise s=%0d got=%b exp=%b", s, locked, s >= 5); else n_pass++;
            n_checks++;
            if (rev_tick !== (s == 9 || s == 13)) $display("FAIL rev_tick s=%0d got=%b", s, rev_tick); else n_pass++;
            n_checks++;
            if (phase !== 2'((s - 1) % 4) || err_onehot || err_seq) $display("FAIL phase_track s=%0d got=%0d eo=%b es=%b", s, phase, err_onehot, err_seq); else n_pass++;
        end
        n_checks++;
        if (rev_count !== 16'd2) $display("FAIL rev_count got=%0d exp=2", rev_count); else n_pass++;
    endtask

    task automatic test_onehot_error();
        step(1, 4'b0011, 0);
        n_checks++;
        if ({err_onehot, locked, err_sticky, phase} !== {1'b1, 1'b0, 1'b1, 2'd0})
            $display("FAIL onehot_err got eo=%b lk=%b st=%b ph=%0d exp 1 0 1 0", err_onehot, locked, err_sticky, phase); else n_pass++;
        for (int s = 1; s <= 5; s++) begin
            step(1, 4'b0001 << ((s - 1) % 4), 0);
            n_checks++;
            if (dut_vec() !== mdl_vec() || locked !== (s == 5) || err_onehot)
                $display("FAIL relock s=%0d got=%h exp=%h", s, dut_vec(), mdl_vec()); else n_pass++;
        end
    endtask

    task automatic test_seq_error();
        step(1, 4'b0010, 0);
        step(1, 4'b1000, 0);
        n_checks++;
        if ({err_seq, locked, phase} !== {1'b1, 1'b0, 2'd3})
            $display("FAIL seq_err got es=%b lk=%b ph=%0d exp 1 0 3", err_seq, locked, phase); else n_pass++;
        for (int s = 1; s <= 4; s++) begin
            step(1, 4'b0001 << (s - 1), 0);
            n_checks++;
            if (dut_vec() !== mdl_vec() || locked !== (s == 4))
                $display("FAIL seq_relock s=%0d got=%h exp=%h", s, dut_vec(), mdl_vec()); else n_pass++;
        end
    endtask

    task automatic test_enable_hold();
        for (int s = 0; s < 10; s++) begin
            step(0, 4'b1111, 0);
            n_checks++;
            if (dut_vec() !== mdl_vec() || err_onehot || err_seq || rev_tick || !locked || phase !== 2'd3)
                $display("FAIL en_hold c=%0d got=%h exp=%h", s, dut_vec(), mdl_vec()); else n_pass++;
        end
        step(1, 4'b0001, 0);
        n_checks++;
        if (locked !== 1'b1 || dut_vec() !== mdl_vec()) $display("FAIL en_resume got=%h exp=%h", dut_vec(), mdl_vec()); else n_pass++;
    endtask

    task automatic test_clr_tick();
        step(1, 4'b0010, 0);
        step(1, 4'b0100, 0);
        step(1, 4'b1000, 0);
        step(1, 4'b0001, 1);
        n_checks++;
        if ({rev_tick, rev_count, err_sticky} !== {1'b1, 16'd1, 1'b0})
            $display("FAIL clr_tick got rt=%b rc=%0d st=%b exp 1 1 0", rev_tick, rev_count, err_sticky); else n_pass++;
    endtask

    task automatic test_async_reset();
        step(1, 4'b0010, 0);
        #2 rst_n = 1'b0;
        #2;
        n_checks++;
        if (dut_vec() !== 31'h0) $display("FAIL async_reset got=%h exp=0", dut_vec()); else n_pass++;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_err_count();
        logic [3:0] bad;
        for (int s = 0; s < 300; s++) begin
            do bad = 4'($urandom); while ($countones(bad) == 1);
            step(1, bad, 0);
        end
        n_checks++;
`ifdef RING_SEQ_MON_ERRCNT_EN
        if (err_count !== 8'd255) $display("FAIL err_sat got=%0d exp=255", err_count); else n_pass++;
`else
        if (err_count !== 8'd0) $display("FAIL err_tied got=%0d exp=0", err_count); else n_pass++;
`endif
        step(1, 4'b0001, 1);
        n_checks++;
        if (err_count !== 8'd0 || err_sticky !== 1'b0) $display("FAIL err_clr got ec=%0d st=%b exp 0 0", err_count, err_sticky); else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] r;
        bit e, c;
        for (int s = 0; s < 600; s++) begin
            e = ($urandom_range(0, 9) < 8);
            c = e && ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) < 17) r = 4'b0001 << ((m_phase + 1) % W);
            else r = 4'($urandom);
            step(e, r, c);
            n_checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL random s=%0d ring=%b got=%h exp=%h", s, r, dut_vec(), mdl_vec()); else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_sequence();
        test_onehot_error();
        test_seq_error();
        test_enable_hold();
        test_clr_tick();
        test_async_reset();
        test_err_count();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ring_sequence_monitor.md
# ring_sequence_monitor

- Downstream consumer of the 4-bit one-hot rotating ring counter.
- Samples the ring code every enabled cycle and checks that it is strictly one-hot and advances exactly one position per sample: 0001→0010→0100→1000→0001.
- Reports the encoded phase, lock status, error pulses, a sticky error flag and a revolution count.
- Serves as the health monitor between the ring counter and the phase-driven logic it feeds.

## Interface
Parameters:
- WIDTH, 4, ring width in bits; WIDTH ≥ 2.
- LOCK_COUNT, 4, consecutive valid transitions required to declare lock; LOCK_COUNT ≥ 1.
- REV_W, 16, revolution counter width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; when 0, all state and outputs hold.
- ring_in  in  WIDTH  ring code from the upstream counter.
- clr  in  1  synchronous clear of rev_count, err_sticky and err_count.
- phase  out  $clog2(WIDTH)  index of the hot bit in the last accepted one-hot sample.
- locked  out  1  high while FSM is in LOCKED.
- err_onehot  out  1  one-cycle pulse: sample was not one-hot.
- err_seq  out  1  one-cycle pulse: one-hot sample was not the expected rotation.
- err_sticky  out  1  set by any error; cleared only by clr or reset.
- rev_tick  out  1  one-cycle pulse on a wrap to index 0 while LOCKED.
- rev_count  out  REV_W  count of rev_tick pulses; wraps modulo 2^REV_W.
- err_count  out  8  saturating error count (see Configuration).

## Operation
- Expected next sample: {prev[WIDTH-2:0], prev[WIDTH-1]}. A one-hot sample is valid when it equals the expected next sample, i.e. index = (prev_index+1) mod WIDTH.
- A repeated (stalled) sample is a sequence error.
- FSM states: SEARCH (no reference), ACQUIRE, LOCKED. good_cnt counts consecutive valid transitions.
- SEARCH, en=1:
  - One-hot sample: store it as prev, update phase, good_cnt=0, go to ACQUIRE.
  - Not one-hot: pulse err_onehot, stay in SEARCH.
- ACQUIRE or LOCKED, en=1:
  - Not one-hot: pulse err_onehot, go to SEARCH, good_cnt=0; prev and phase hold.
  - One-hot but unexpected: pulse err_seq, go to ACQUIRE, prev and phase take the new sample, good_cnt=0.
  - Valid transition: prev and phase update.
    - In ACQUIRE: good_cnt+1; go to LOCKED when good_cnt+1 == LOCK_COUNT.
    - In LOCKED: stay in LOCKED.
- rev_tick: asserted only when the state was already LOCKED before the edge and the valid transition lands on index 0. The edge that enters LOCKED never ticks.
- err_sticky: set on any err_onehot or err_seq pulse.
- clr ordering: clr is applied first, then same-cycle events. clr with rev_tick gives rev_count=1; clr with an error gives err_sticky=1. clr does not affect the FSM, phase or locked.
- Reset values: state SEARCH, good_cnt 0, prev 0, phase 0, locked 0, err_onehot 0, err_seq 0, err_sticky 0, rev_tick 0, rev_count 0, err_count 0.

## Timing
- All outputs are registered. ring_in sampled at edge N is reflected on outputs immediately after edge N; latency is 1 cycle.
- Pulses last exactly one cycle and are never asserted when en=0.
- rst_n assertion clears all outputs immediately, without waiting for a clock edge. This holds even mid-lock.
- Deassertion of rst_n is synchronous to clk, handled by the upstream reset synchronizer.
- With continuous valid input, locked rises after sample LOCK_COUNT+1. Lock drops in the same cycle an error pulse is reported.

## Configuration
- RING_SEQ_MON_ERRCNT_EN defined:
  - err_count increments by 1 on each err_onehot or err_seq pulse and saturates at 255.
  - clr zeroes it; an error in the same cycle as clr gives 1.
- Not defined: err_count is tied to 0 and no counter logic is built. The port is always present.

## Test plan
All scenarios use WIDTH=4, LOCK_COUNT=4.
- Reset, en=1, feed 0001,0010,0100,1000 repeating for 13 samples → locked=1 after sample 5; rev_tick at samples 9 and 13 only; rev_count=2; no error pulses; phase tracks 0,1,2,3.
- While LOCKED, feed 0011 → err_onehot pulses for one cycle, locked=0, state SEARCH, err_sticky=1, phase unchanged. Then feed valid 0001.. → relock after 5 samples.
- While LOCKED at 0010, feed 1000 → err_seq pulse, locked=0, phase=3. Then 0001,0010,0100,1000 → locked=1 after the 4th.
- en=0 for 10 cycles with ring_in=1111 → no outputs change, no pulses; resume en=1 with the expected value → stays LOCKED.
- clr asserted in the same cycle as a rev_tick → rev_count=1, err_sticky=0. Drop rst_n between clock edges while LOCKED → all outputs 0 before the next edge.
- With RING_SEQ_MON_ERRCNT_EN defined, inject 300 non-one-hot samples → err_count=255; clr → 0. Without the macro → err_count stays 0.
